// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: captures a byte on each falling
// edge of rx_int and presents it first-word fall-through to the consumer.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_int,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  rx_int_d;
    logic                  wr_ev;
    logic                  rd_en;
    logic                  wr_en;
    logic                  drop;

    // rx_data changes on the same edge rx_int falls, so sample it now
    assign wr_ev = rx_int_d & ~rx_int;
    assign rd_en = rd_valid & rd_ready;
    assign wr_en = wr_ev & (~full | rd_en);
    assign drop  = wr_ev & full & ~rd_en;

    assign rd_valid = (level != '0);
    assign full     = (level == LVL_FULL);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_int_d <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            rx_int_d <= rx_int;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // a drop in the same cycle as a clear still leaves the flag set
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios then random traffic,
// compared against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_int;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic       ovf_clr;

    int vectors;
    int miscompares;

    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_prev;

    uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_int   (rx_int),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 8'h00;
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("rd_data", 32'(rd_data), 32'(exp_data));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 16));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic ri, input logic [7:0] d,
                        input logic rr, input logic oc);
        bit wr;
        bit rd;
        bit dropped;
        rx_int   = ri;
        rx_data  = d;
        rd_ready = rr;
        ovf_clr  = oc;
        @(posedge clk);
        wr      = m_prev && !ri;
        rd      = (q.size() != 0) && rr;
        dropped = 1'b0;
        if (rd) void'(q.pop_front());
        if (wr) begin
            if (q.size() < 16) q.push_back(d);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        m_prev = ri;
        #1;
        check_all();
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic rr,
                           input logic oc);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, d, rr, oc);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rx_int   = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        rst_n    = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rx_data     = 8'h00;
        rx_int      = 1'b0;
        rd_ready    = 1'b0;
        ovf_clr     = 1'b0;
        rst_n       = 1'b1;
        #2;
        do_reset();
        // rx_int already low after reset must not write
        step(1'b0, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'hEE, 1'b0, 1'b0);

        wr_byte(8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) wr_byte(8'(i), 1'b0, 1'b0);
        wr_byte(8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        drain(17);

        for (int i = 0; i < 16; i++) wr_byte(8'(8'h80 + i), 1'b0, 1'b0);
        wr_byte(8'h77, 1'b1, 1'b0);
        wr_byte(8'h99, 1'b0, 1'b1);
        drain(17);
        step(1'b1, 8'h00, 1'b0, 1'b1);

        wr_byte(8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) wr_byte(8'(8'h31 + i), 1'b1, 1'b0);
        wr_byte(8'hC0, 1'b0, 1'b0);
        drain(4);

        for (int i = 0; i < 5; i++) wr_byte(8'(8'h60 + i), 1'b0, 1'b0);
        wr_byte(8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) wr_byte(8'h12, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h00, 1'b0, 1'b0);
        wr_byte(8'h3C, 1'b0, 1'b0);
        drain(2);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0));
        end
        drain(18);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning byte width of rx_data and rd_data.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth of 2**DEPTH_LOG2 entries (16).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  DATA_W  received byte from the UART receiver.
REQ-006 SHALL have port rx_int  input  1  receiver busy flag: high during a frame, falls when rx_data is updated.
REQ-007 SHALL have port rd_data  output  DATA_W  head-of-FIFO byte (first-word fall-through).
REQ-008 SHALL have port rd_valid  output  1  FIFO non-empty; rd_data is meaningful.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-010 SHALL have port level  output  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2.
REQ-011 SHALL have port full  output  1  level equals 2**DEPTH_LOG2.
REQ-012 SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL register rx_int into rx_int_d every cycle and detect a write event as rx_int_d=1 and rx_int=0.
REQ-015 SHALL sample rx_data in the cycle of the write event, because the receiver updates rx_data on the same edge that it deasserts rx_int.
REQ-016 SHALL, on a write event with full=0 or with a simultaneous read (see REQ-019), store rx_data at wr_ptr, increment wr_ptr modulo depth, and make the byte visible on rd_data/rd_valid one cycle later.
REQ-017 SHALL, on a read (rd_valid=1 and rd_ready=1), advance rd_ptr modulo depth so that the next entry appears on rd_data the next cycle.
REQ-018 SHALL ignore rd_ready while rd_valid=0: no pointer or level change.
REQ-019 SHALL, on a simultaneous write and read, keep level unchanged; this SHALL apply when full (the write is accepted and no overflow occurs) and SHALL NOT apply when empty (there is no read because rd_valid=0, so level becomes 1).
REQ-020 SHALL, on a write event with full=1 and no simultaneous read, discard the byte, leave pointers and level unchanged, and set overflow on the next edge.
REQ-021 SHALL give priority to setting overflow over ovf_clr when both occur in the same cycle.
REQ-022 SHALL update level as: +1 on write only, -1 on read only, unchanged on both or neither; level SHALL never exceed 2**DEPTH_LOG2 or go below 0.
REQ-023 SHALL wrap pointers from 2**DEPTH_LOG2-1 to 0 with no data corruption; full and empty SHALL be derived from level, not from pointer equality alone.
REQ-024 SHALL drive rd_valid = (level != 0), full = (level == 2**DEPTH_LOG2), and rd_data = mem[rd_ptr], all registered or derived combinationally from registers only.
REQ-025 SHALL produce at most one write per rx_int falling edge; rx_int held low or high indefinitely SHALL produce no writes.

Reset
REQ-026 SHALL, while rst_n=0, force wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, full=0, overflow=0, and rx_int_d=0.
REQ-027 SHALL force rd_data to 0 during reset; storage contents need not be cleared.
REQ-028 SHALL, on reset asserted mid-frame or mid-read, discard all stored bytes.
REQ-029 SHALL treat the first cycle after reset as having rx_int_d=0, so that an rx_int that is already low produces no spurious write.

Verification
REQ-030 Single byte: pulse rx_int 1->0 with rx_data=8'hA5 and hold rd_ready=0 -> the next cycle shows rd_valid=1, rd_data=8'hA5, level=1; then assert rd_ready for one cycle -> rd_valid=0, level=0.
REQ-031 Fill: write 16 bytes 8'h00..8'h0F with no reads -> full=1, level=16; a 17th write of 8'h55 -> overflow=1, level=16, and reading all 16 returns 8'h00..8'h0F in order.
REQ-032 Full simultaneous: with level=16, write 8'h77 while reading -> level=16, overflow=0, and 8'h77 is read last.
REQ-033 Wrap: write and read 40 bytes interleaved with level kept between 1 and 3 -> data order is preserved across two pointer wraps.
REQ-034 Overflow clear: with overflow=1, assert ovf_clr -> overflow=0; assert ovf_clr in the same cycle as an overflowing write -> overflow=1.
REQ-035 Reset mid-operation: with level=5, assert rst_n=0 for one cycle -> level=0, rd_valid=0, overflow=0, and the next write is read back correctly.
